// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: scancode FIFO with level irq for the CPU, plus a command
// path that transmits a byte, waits for the device ACK and retries on resend.
module ps2_kbd_ctrl #(
  parameter int clkf           = 50000000,
  parameter int FIFO_DEPTH     = 8,
  parameter int ACK_TIMEOUT_MS = 20,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       data_m_access,
  input  logic       data_m_wr_en,
  input  logic       data_m_addr,
  input  logic [7:0] data_m_data_in,
  output logic [7:0] data_m_data_out,
  output logic       data_m_ack,
  input  logic [7:0] ps2_rx,
  input  logic       ps2_rx_valid,
  input  logic       ps2_error,
  output logic       ps2_start_tx,
  output logic [7:0] ps2_tx,
  input  logic       ps2_tx_busy,
  input  logic       ps2_tx_complete,
  output logic       irq
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RELOAD = (clkf / 1000) * ACK_TIMEOUT_MS;
  localparam int TMR_W  = $clog2(RELOAD) + 1;
  localparam int RTY_W  = $clog2(MAX_RETRIES + 1) + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, WAIT_ACK} state_t;

  state_t           state;
  logic [7:0]       cmd;
  logic             cmd_error;
  logic [RTY_W-1:0] retries;
  logic [TMR_W-1:0] timer;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             parity_err;
  logic             overflow;

  logic access, rd_data, wr_data, rd_status, wr_status;
  logic fifo_empty, fifo_full, pop, push, push_req, flush, ovf_set, perr_set;
  logic fsm_consume, cmd_busy;
  logic [7:0] status;

  assign access    = cs & data_m_access & ~data_m_ack;
  assign rd_data   = access & ~data_m_wr_en & ~data_m_addr;
  assign wr_data   = access &  data_m_wr_en & ~data_m_addr;
  assign rd_status = access & ~data_m_wr_en &  data_m_addr;
  assign wr_status = access &  data_m_wr_en &  data_m_addr;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign cmd_busy   = (state != IDLE);

  // ACK, resend and any errored byte belong to the command handshake while waiting for it
  assign fsm_consume = (state == WAIT_ACK) & ps2_rx_valid &
                       (ps2_error | (ps2_rx == 8'hFA) | (ps2_rx == 8'hFE));

  assign pop      = rd_data & ~fifo_empty;
  assign flush    = wr_status & data_m_data_in[0];
  assign push_req = ps2_rx_valid & ~ps2_error & ~fsm_consume;
  assign push     = push_req & (~fifo_full | pop);
  assign ovf_set  = push_req & fifo_full & ~pop;
  assign perr_set = ps2_rx_valid & ps2_error;

  assign status = {3'b000, parity_err, overflow, cmd_error, cmd_busy, ~fifo_empty};
  assign irq    = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= ps2_rx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      parity_err      <= 1'b0;
      overflow        <= 1'b0;
      data_m_ack      <= 1'b0;
      data_m_data_out <= 8'h00;
    end else begin
      data_m_ack <= access;
      if (rd_data)
        data_m_data_out <= fifo_empty ? 8'h00 : mem[rd_ptr];
      else if (rd_status)
        data_m_data_out <= status;
      else
        data_m_data_out <= 8'h00;

      parity_err <= perr_set | (parity_err & ~rd_status);
      overflow   <= ovf_set  | (overflow   & ~rd_status);

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cmd          <= 8'h00;
      cmd_error    <= 1'b0;
      retries      <= '0;
      timer        <= '0;
      ps2_start_tx <= 1'b0;
      ps2_tx       <= 8'h00;
    end else begin
      ps2_start_tx <= 1'b0;
      ps2_tx       <= 8'h00;
      case (state)
        IDLE: begin
          if (wr_data) begin
            cmd       <= data_m_data_in;
            cmd_error <= 1'b0;
            retries   <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (!ps2_tx_busy) begin
            ps2_start_tx <= 1'b1;
            ps2_tx       <= cmd;
            timer        <= TMR_W'(RELOAD);
            state        <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (ps2_tx_complete) begin
            timer <= TMR_W'(RELOAD);
            state <= WAIT_ACK;
          end else if (timer == '0) begin
            cmd_error <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        WAIT_ACK: begin
          if (ps2_rx_valid && !ps2_error && ps2_rx == 8'hFA) begin
            state <= IDLE;
          end else if (ps2_rx_valid && (ps2_error || ps2_rx == 8'hFE)) begin
            if (retries < RTY_W'(MAX_RETRIES)) begin
              retries <= retries + RTY_W'(1);
              state   <= SEND;
            end else begin
              cmd_error <= 1'b1;
              state     <= IDLE;
            end
          end else if (timer == '0) begin
            cmd_error <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
